// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Bit count needed to index WIDTH multiplier bits (WIDTH >= 2).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector; history resets to "high" so a level held through reset is not an edge.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = sig;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = sig & ~prev_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock, busy/done handshake.
// Define SEQ_MULT_SIGNED_EN to add the signed_mode port and two's-complement support.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     md,
    input  logic [WIDTH-1:0]     mr,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 signed_mode,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_md_q, acc_md_d;
    logic [WIDTH-1:0]     acc_mr_q, acc_mr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;
    logic                 start_rise;
    logic [WIDTH-1:0]     md_in, mr_in;
    logic                 neg_in, neg_now;
    logic [2*WIDTH-1:0]   sum;

    edge_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .sig   (start),
        .rise  (start_rise)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic neg_q, neg_d;

    // Magnitude of a two's-complement value; -2^(W-1) maps onto itself, read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    always_comb begin
        md_in  = signed_mode ? magnitude(md) : md;
        mr_in  = signed_mode ? magnitude(mr) : mr;
        neg_in = signed_mode & (md[WIDTH-1] ^ mr[WIDTH-1]);
        neg_d  = neg_q;
        if (state_q == ST_IDLE && start_rise) begin
            neg_d = neg_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end

    assign neg_now = neg_q;
`else
    assign md_in   = md;
    assign mr_in   = mr;
    assign neg_in  = 1'b0;
    assign neg_now = neg_in;
`endif

    assign sum = acc_q + (acc_mr_q[0] ? acc_md_q : '0);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_md_d  = acc_md_q;
        acc_mr_d  = acc_mr_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    acc_md_d = {{WIDTH{1'b0}}, md_in};
                    acc_mr_d = mr_in;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d    = sum;
                acc_md_d = acc_md_q << 1;
                acc_mr_d = acc_mr_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Result registers load on the final add so product and done appear together in FINISH.
                if (cnt_q == CNT_LAST) begin
                    product_d = neg_now ? -sum : sum;
                    done_d    = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            acc_md_q  <= '0;
            acc_mr_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_md_q  <= acc_md_d;
            acc_mr_q  <= acc_mr_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH = 8): driver predicts results, monitor checks them.
module tb_seq_multiplier;

    localparam int W = 8;
`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   md = '0;
    logic [W-1:0]   mr = '0;
    logic           sm_tb = 1'b0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .md          (md),
        .mr          (mr),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (sm_tb),
`endif
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] p;
        int             cyc;
    } exp_t;

    exp_t           q[$];
    int             cyc = 0;
    int             n_tests = 0;
    int             n_fail = 0;
    bit             mon_en = 1'b0;
    logic           prev_start = 1'b1;
    int             free_at = 0;
    int             busy_from = 1;
    int             busy_to = 0;
    logic [2*W-1:0] hold_prod = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sm);
        logic signed [2*W-1:0] ps;
        logic [2*W-1:0]        pu;
        ps = $signed(a) * $signed(b);
        pu = a * b;
        return (sm && SGN) ? ps : pu;
    endfunction

    // Drives one cycle of inputs and advances the reference model of the request/accept rules.
    task automatic step(input logic s, input logic rst, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sm);
        exp_t e;
        @(negedge clk);
        start = s;
        reset = rst;
        md    = a;
        mr    = b;
        sm_tb = sm;
        if (rst) begin
            q.delete();
            prev_start = 1'b1;
            free_at    = cyc + 1;
            if (busy_to > cyc) busy_to = cyc;
            hold_prod  = '0;
        end else begin
            if (s && !prev_start && cyc >= free_at) begin
                e.p   = ref_mult(a, b, sm);
                e.cyc = cyc + W + 1;
                q.push_back(e);
                busy_from = cyc + 1;
                busy_to   = cyc + W;
                free_at   = cyc + W + 2;
            end
            prev_start = s;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, md, mr, sm_tb);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        step(1'b1, 1'b0, a, b, sm);
        idle(W + 2);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            check("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("product", 32'(product), 32'(e.p));
                    hold_prod = e.p;
                end
            end else begin
                check("product_hold", 32'(product), 32'(hold_prod));
                if (q.size() != 0 && cyc >= q[0].cyc) begin
                    check("missing_done", 32'(done), 32'd1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        step(1'b0, 1'b1, '0, '0, 1'b0);
        step(1'b0, 1'b1, '0, '0, 1'b0);
        mon_en = 1'b1;
        idle(3);

        op(8'd13, 8'd11, 1'b0);
        op(8'd255, 8'd255, 1'b0);
        idle(4);
        op(8'd0, 8'd200, 1'b0);

        // Long hold with a short dip while busy: only the first edge counts.
        for (int i = 0; i < 30; i++) step((i != 4), 1'b0, 8'd7, 8'd9, 1'b0);
        idle(W + 3);

        // Reset mid-RUN with start held, then a fresh edge afterwards.
        step(1'b1, 1'b0, 8'd100, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd100, 8'd3, 1'b0);
        step(1'b1, 1'b1, 8'd100, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd100, 8'd3, 1'b0);
        step(1'b0, 1'b0, 8'd100, 8'd3, 1'b0);
        op(8'd21, 8'd2, 1'b0);

        // Edge in FINISH ignored; edge at W+2 accepted.
        step(1'b1, 1'b0, 8'd50, 8'd60, 1'b0);
        idle(W);
        step(1'b1, 1'b0, 8'd1, 8'd1, 1'b0);
        step(1'b0, 1'b0, 8'd1, 8'd1, 1'b0);
        step(1'b1, 1'b0, 8'd17, 8'd19, 1'b0);
        idle(W + 1);
        step(1'b1, 1'b0, 8'd200, 8'd201, 1'b0);
        idle(W + 2);

        op(8'hFD, 8'd5, 1'b1);
        op(8'h80, 8'h80, 1'b1);
        op(8'd127, 8'h80, 1'b1);
        op(8'hFD, 8'd5, 1'b0);
        op(8'hFF, 8'h01, 1'b1);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) == 0), 1'b0, 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)));
        end
        idle(W + 3);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-and-add multiplier. It is the successor to the fixed 8-bit multiplier, and the next arithmetic block in the pushbutton-driven datapath. It takes two WIDTH-bit operands on a rising edge of `start` and iterates one multiplier bit per clock. It presents a 2·WIDTH-bit product with a `busy`/`done` handshake, and can optionally do two's-complement signed multiplication.

## Interface
- `WIDTH`, default 8: operand width in bits, ≥ 2. The product is 2·WIDTH bits.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: level request from the debounced pushbutton. Only a 0→1 transition is a request.
- `md` input WIDTH: multiplicand, sampled on an accepted start.
- `mr` input WIDTH: multiplier, sampled on an accepted start.
- `signed_mode` input 1: 1 selects two's-complement operands. The port exists only with `SEQ_MULT_SIGNED_EN`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when `product` becomes valid.
- `product` output 2·WIDTH: result register, held until the next completion.

## Operation
- FSM states: IDLE, RUN, FINISH.
- **IDLE:**
  - On a start rising edge, capture `md` zero-extended to 2·WIDTH into `acc_md` and `mr` into `acc_mr`.
  - Clear the accumulator and the counter. Go to RUN.
- **RUN, each cycle:**
  - If `acc_mr[0]`, then accumulator += `acc_md`. The sum is modulo 2^(2·WIDTH) and cannot overflow for unsigned operands.
  - Shift `acc_md` left by 1 and `acc_mr` right by 1, with zero fill.
  - Increment the counter. When the counter reaches WIDTH−1, go to FINISH.
- **FINISH:**
  - Copy the accumulator to `product`, after sign correction when signed.
  - Assert `done`. Go to IDLE.
- **Start handling:**
  - A start edge is accepted only in IDLE.
  - Edges during RUN or FINISH are discarded, not queued.
  - Holding `start` high gives exactly one operation.
- **Counter width:** $clog2(WIDTH).
- **Operand boundaries:** 0 operands and all-ones operands need no special handling.
- **Reset, at any time including mid-RUN:** state = IDLE, `busy` = 0, `done` = 0, `product` = 0, internal registers cleared. Start-edge history clears to "start was high", so a button held through reset does not trigger an operation.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `product` = 0.
- Cycle 0: start edge seen in IDLE.
- Cycles 1 through WIDTH: RUN, with `busy` = 1.
- Cycle WIDTH+1: FINISH, with `busy` = 0, `done` = 1, and the new `product` visible.
- Latency from start edge to `done` is WIDTH+1 cycles, independent of operand values.
- The earliest next accepted start edge is at cycle WIDTH+2.
- `product` changes only in the FINISH cycle.
- The start edge is detected registered: it compares `start` with its value in the previous cycle.

## Configuration
- **`SEQ_MULT_SIGNED_EN` defined:**
  - The `signed_mode` port exists.
  - When `signed_mode` = 1 at accept, store the absolute value of each operand and the XOR of the sign bits. The magnitude of −2^(WIDTH−1) is 2^(WIDTH−1) and fits unsigned in WIDTH bits.
  - In FINISH, negate the product when the stored sign is 1.
  - `signed_mode` is sampled only at accept.
  - Latency is unchanged.
- **`SEQ_MULT_SIGNED_EN` not defined:** no `signed_mode` port, unsigned only, and no sign logic is synthesised.

## Structure
- Package `seq_mult_pkg` holds:
  - the state enum (IDLE/RUN/FINISH);
  - a function returning the counter width for a given WIDTH.
- Sub-module `edge_detect`: a registered rising-edge detector for `start`, with synchronous reset. Its reset value is 1, as required by the reset rule above.
- Everything else lives in `seq_multiplier`.

## Test plan
All scenarios use WIDTH = 8.
1. md = 13, mr = 11, start edge → `busy` high for 8 cycles; `done` at cycle 9; `product` = 0x008F; `done` stays high for exactly 1 cycle.
2. md = 255, mr = 255, then md = 0, mr = 200 → `product` = 0xFE01, then 0x0000; `product` holds its value between the two `done` pulses.
3. Hold `start` high for 30 cycles, and pulse `start` again at cycle 4 → exactly one `done`; the cycle-4 edge is ignored; `busy` is never re-asserted.
4. Assert `reset` at cycle 5 of RUN while `start` stays high → the next cycle shows `busy` = 0, `done` = 0, `product` = 0; no operation starts until `start` falls and rises again.
5. With `SEQ_MULT_SIGNED_EN` and `signed_mode` = 1:
   - md = −3 (0xFD), mr = 5 → 0xFFF1.
   - md = −128, mr = −128 → 0x4000.
   - md = 127, mr = −128 → 0xC080.
   - With `signed_mode` = 0: md = 0xFD, mr = 5 → 0x04F1.
6. Start edge in the FINISH cycle, then a new edge at cycle WIDTH+2 → the first edge is ignored; the second is accepted and gives its `done` at cycle 2·WIDTH+3.
